// File: rtl/pwm_guard_pkg.sv
// pwm_guard_pkg: channel state encoding and sizing helpers shared by pwm_guard_multi.
package pwm_guard_pkg;
  typedef enum logic [1:0] {RUN, BLANK, TRIPPED} state_t;
  localparam int RAMP_DIV = 16;
  function automatic int width_for(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_guard_channel.sv
// pwm_guard_channel: one PWM enable with duty shadow, leaky fault integrator and RUN/BLANK/TRIPPED guard.
// PWM_GUARD_SOFT_START_EN adds a per-period duty ramp restarted by reset and clear.
module pwm_guard_channel
  import pwm_guard_pkg::*;
#(
  parameter int CNT_W = 21,
  parameter int ACC_W = 23,
  parameter int TRIP_COUNT = 8000000,
  parameter int BLANK_CYCLES = 5
`ifdef PWM_GUARD_SOFT_START_EN
  , parameter int RAMP_STEP = 1
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic             fault_n,
  output logic             enable,
  output logic             tripped
);
  localparam int BW = width_for(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);
  localparam logic [ACC_W-1:0] TRIP = ACC_W'(TRIP_COUNT);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  state_t state, state_nxt;
  logic [CNT_W-1:0] shadow, shadow_nxt, level;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [BW-1:0] blank, blank_nxt;
  logic fault, trip;
  assign fault = !fault_n;
  assign shadow_nxt = start ? duty : shadow;
  assign acc_nxt = fault ? (acc == ACC_MAX ? acc : acc + ACC_W'(1)) : (acc == '0 ? acc : acc - ACC_W'(1));
  assign trip = acc_nxt >= TRIP;
  assign tripped = state == TRIPPED;
  // trip outranks blanking; clear outranks everything including a fault in the same cycle
  always_comb begin
    state_nxt = clear ? RUN : (state == TRIPPED || trip) ? TRIPPED :
                state == RUN ? (fault ? BLANK : RUN) : (blank == '0 && !fault) ? RUN : BLANK;
    blank_nxt = state_nxt != BLANK ? '0 : (state != BLANK || blank == '0) ? BLANK_LOAD : blank - BW'(1);
  end
`ifdef PWM_GUARD_SOFT_START_EN
  localparam int SW = CNT_W + 1;
  localparam logic [SW-1:0] STEP = SW'(RAMP_STEP);
  logic [CNT_W-1:0] ramp, ramp_nxt;
  logic [SW-1:0] ramp_sum;
  assign ramp_sum = {1'b0, ramp} + STEP;
  assign ramp_nxt = clear ? '0 : !start ? ramp : ramp_sum >= {1'b0, shadow_nxt} ? shadow_nxt : ramp_sum[CNT_W-1:0];
  assign level = ramp_nxt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) ramp <= '0;
    else ramp <= ramp_nxt;
`else
  assign level = shadow_nxt;
`endif
  // compare against the value loaded this edge so a new duty covers its whole period
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= RUN;
      shadow <= '0;
      acc <= '0;
      blank <= '0;
      enable <= 1'b0;
    end else begin
      state <= state_nxt;
      shadow <= shadow_nxt;
      acc <= clear ? '0 : state == TRIPPED ? acc : acc_nxt;
      blank <= blank_nxt;
      enable <= state_nxt == RUN && cnt < level;
    end
endmodule

// File: rtl/pwm_guard_multi.sv
// pwm_guard_multi: N-channel guarded PWM enable generator with a shared period counter.
// Define PWM_GUARD_SOFT_START_EN to ramp each channel's duty up after reset or clear.
module pwm_guard_multi
  import pwm_guard_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W = 21,
  parameter int PERIOD = 1666667,
  parameter int ACC_W = 23,
  parameter int TRIP_COUNT = 8000000,
  parameter int BLANK_CYCLES = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [CHANNELS*CNT_W-1:0] duty,
  input  logic [CHANNELS-1:0]       fault_n,
  output logic [CHANNELS-1:0]       enable,
  output logic [CHANNELS-1:0]       tripped,
  output logic                      period_start
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  logic [CNT_W-1:0] cnt;
  logic start;
  assign start = cnt == '0;
  // period_start is registered so that it is high exactly while cnt is 0
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt <= '0;
      period_start <= 1'b0;
    end else begin
      cnt <= cnt == LAST ? '0 : cnt + CNT_W'(1);
      period_start <= cnt == LAST;
    end
  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    pwm_guard_channel #(
      .CNT_W(CNT_W),
      .ACC_W(ACC_W),
      .TRIP_COUNT(TRIP_COUNT),
      .BLANK_CYCLES(BLANK_CYCLES)
`ifdef PWM_GUARD_SOFT_START_EN
      , .RAMP_STEP(PERIOD / RAMP_DIV)
`endif
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .clear(clear),
      .start(start),
      .cnt(cnt),
      .duty(duty[g*CNT_W +: CNT_W]),
      .fault_n(fault_n[g]),
      .enable(enable[g]),
      .tripped(tripped[g])
    );
  end
endmodule

// File: tb/tb_pwm_guard_multi.sv
// tb_pwm_guard_multi: table, directed and random checks of pwm_guard_multi against a cycle-count reference model.
module tb_pwm_guard_multi;
  localparam int CH = 2, CW = 21, P = 100, AW = 8, TC = 50, BC = 4;
  localparam int ACC_MAX = (1 << AW) - 1;
  logic clock = 1'b0, reset = 1'b0, clear = 1'b0;
  logic [CH*CW-1:0] duty = '0;
  logic [CH-1:0] fault_n = '1;
  logic [CH-1:0] enable, tripped;
  logic period_start;
  pwm_guard_multi #(
    .CHANNELS(CH), .CNT_W(CW), .PERIOD(P), .ACC_W(AW), .TRIP_COUNT(TC), .BLANK_CYCLES(BC)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear), .duty(duty), .fault_n(fault_n),
    .enable(enable), .tripped(tripped), .period_start(period_start)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_fail = 0;
  int m_t;
  int m_sh[CH], m_acc[CH], m_blk[CH];
  logic [CH-1:0] m_trip, m_en;
  logic m_ps;
  int hi[CH];
  int n_ps;
  typedef struct { int d0; int d1; int e0; int e1; } row_t;
  row_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_duty(input int d0, input int d1);
    duty = {CW'(d1), CW'(d0)};
  endtask

  task automatic model_reset();
    m_t = 0;
    m_trip = '0;
    m_en = '0;
    m_ps = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_sh[c] = 0;
      m_acc[c] = 0;
      m_blk[c] = 0;
    end
  endtask

  // m_blk is the number of blanked cycles still owed; the last one re-arms if the fault persists
  task automatic model_step();
    int pos;
    bit f;
    pos = m_t % P;
    m_ps = pos == P - 1;
    for (int c = 0; c < CH; c++) begin
      f = !fault_n[c];
      if (pos == 0) m_sh[c] = int'(duty[c*CW +: CW]);
      if (clear) begin
        m_trip[c] = 1'b0;
        m_acc[c] = 0;
        m_blk[c] = 0;
      end else if (!m_trip[c]) begin
        m_acc[c] = f ? (m_acc[c] < ACC_MAX ? m_acc[c] + 1 : m_acc[c]) : (m_acc[c] > 0 ? m_acc[c] - 1 : 0);
        if (m_acc[c] >= TC) m_trip[c] = 1'b1;
        else m_blk[c] = m_blk[c] <= 1 ? (f ? BC : 0) : m_blk[c] - 1;
      end
      m_en[c] = !m_trip[c] && m_blk[c] == 0 && pos < m_sh[c];
    end
    m_t++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("enable", enable, m_en);
    chk("tripped", tripped, m_trip);
    chk("period_start", period_start, m_ps);
    for (int c = 0; c < CH; c++) hi[c] += int'(enable[c]);
    n_ps += int'(period_start);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_counts();
    hi[0] = 0;
    hi[1] = 0;
    n_ps = 0;
  endtask

  initial begin
    model_reset();
    clr_counts();
    tbl[0] = '{25, 100, 25, 100};
    tbl[1] = '{25, 100, 25, 100};
    tbl[2] = '{0, 150, 0, 100};
    tbl[3] = '{50, 1, 50, 1};
    tbl[4] = '{100, 99, 100, 99};
    #12;
    chk("reset_enable", enable, 0);
    chk("reset_tripped", tripped, 0);
    chk("reset_period_start", period_start, 0);
    @(negedge clock) reset = 1'b1;
    for (int r = 0; r < 5; r++) begin
      set_duty(tbl[r].d0, tbl[r].d1);
      clr_counts();
      ticks(P);
      chk("tbl_hi0", hi[0], tbl[r].e0);
      chk("tbl_hi1", hi[1], tbl[r].e1);
      chk("tbl_ps", n_ps, 1);
    end
    set_duty(25, 1);
    clr_counts();
    ticks(40);
    set_duty(75, 1);
    ticks(60);
    chk("mid_keep", hi[0], 25);
    clr_counts();
    ticks(P);
    chk("mid_next", hi[0], 75);
    set_duty(50, 100);
    clr_counts();
    ticks(10);
    fault_n[0] = 1'b0;
    tick();
    fault_n[0] = 1'b1;
    ticks(89);
    chk("pulse_hi0", hi[0], 46);
    chk("pulse_hi1", hi[1], 100);
    chk("pulse_trip", tripped[0], 0);
    fault_n[0] = 1'b0;
    ticks(49);
    chk("trip_49", tripped[0], 0);
    tick();
    chk("trip_50", tripped[0], 1);
    fault_n[0] = 1'b1;
    clr_counts();
    ticks(150);
    chk("trip_hold", hi[0], 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_trip", tripped[0], 0);
    clr_counts();
    ticks(P);
    chk("clear_resume", hi[0], 50);
    fault_n[0] = 1'b0;
    ticks(50);
    chk("retrip", tripped[0], 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cf_clear", tripped[0], 0);
    tick();
    chk("cf_blank", enable[0], 0);
    ticks(48);
    chk("cf_49", tripped[0], 0);
    tick();
    chk("cf_50", tripped[0], 1);
    fault_n[0] = 1'b1;
    ticks(30);
    chk("pre_rst_en1", enable[1], 1);
    chk("pre_rst_trip0", tripped[0], 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_enable", enable, 0);
    chk("rst_tripped", tripped, 0);
    chk("rst_ps", period_start, 0);
    model_reset();
    set_duty(30, 60);
    @(negedge clock) reset = 1'b1;
    clr_counts();
    ticks(P);
    chk("post_hi0", hi[0], 30);
    chk("post_hi1", hi[1], 60);
    chk("post_ps", n_ps, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) set_duty(int'($urandom_range(120)), int'($urandom_range(120)));
      for (int c = 0; c < CH; c++)
        if (fault_n[c] ? $urandom_range(14) == 0 : $urandom_range(29) == 0) fault_n[c] = ~fault_n[c];
      clear = $urandom_range(299) == 0;
      tick();
    end
    clear = 1'b0;
    fault_n = '1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
